// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 field widths, integer limits and enums for the converter and adder code
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp_class_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: combinational unpack of an fp32 operand into class, sign, unbiased exponent and 24-bit significand
module fp32_classify
  import fp32_pkg::*;
(
  input  logic              [31:0] data,
  output fp_class_t                cls,
  output logic                     sign,
  output logic signed       [9:0]  e,
  output logic              [23:0] m
);
  logic [EXP_W-1:0] ex;
  logic [MANT_W-1:0] mant;
  assign {sign, ex, mant} = data;
  assign cls = &ex ? (|mant ? NAN : INF) : ex == '0 ? (|mant ? SUBNORM : ZERO) : NORMAL;
  assign e = 10'(ex) - 10'(BIAS);
  assign m = {|ex, mant};
endmodule

// File: rtl/fp32_to_int32_seq.sv
// fp32_to_int32_seq: multi-cycle fp32 -> int32 converter (RNE, saturating); FP_CVT_UNSIGNED_EN adds a uint32 target
module fp32_to_int32_seq
  import fp32_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
`ifdef FP_CVT_UNSIGNED_EN
  input  logic        in_unsigned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        invalid,
  output logic        inexact
);
  localparam logic [5:0] SPC = 6'(SHIFT_PER_CYCLE);
  state_t state, nxt;
  fp_class_t c_cls;
  logic c_sign, u_in, sp, left, left_r, sgn, uns, g, s, rup, x;
  logic signed [9:0] c_e;
  logic [23:0] c_m;
  logic [5:0] cnt, rem, n;
  logic [4:0] gi;
  logic [31:0] val, lo;
  logic [32:0] mag;
  logic [33:0] sp_r, res_r;
  fp32_classify u_cls (.data(in_data), .cls(c_cls), .sign(c_sign), .e(c_e), .m(c_m));
`ifdef FP_CVT_UNSIGNED_EN
  assign u_in = in_unsigned;
`else
  assign u_in = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Operands that cannot reach the shifter resolve at accept
  always_comb begin
    sp = 1'b1;
    sp_r = '0;
    if (c_cls == NAN) sp_r = {u_in ? UINT32_MAX : INT32_MAX, 2'b10};
    else if (c_cls == INF) sp_r = {u_in ? (c_sign ? 32'd0 : UINT32_MAX) : (c_sign ? INT32_MIN : INT32_MAX), 2'b10};
    else if (c_cls == SUBNORM) sp_r = {32'd0, 2'b01};
    else if (c_cls == NORMAL) begin
      if (u_in && c_sign && c_e >= 10'sd0) sp_r = {32'd0, 2'b10};
      else if (u_in && !c_sign && c_e >= 10'sd32) sp_r = {UINT32_MAX, 2'b10};
      else if (!u_in && !c_sign && c_e >= 10'sd31) sp_r = {INT32_MAX, 2'b10};
      else if (!u_in && c_sign && (c_e > 10'sd31 || (c_e == 10'sd31 && |c_m[22:0]))) sp_r = {INT32_MIN, 2'b10};
      else sp = 1'b0;
    end
  end
  assign left = c_e >= 10'sd23;
  assign cnt = 6'(left ? c_e - 10'sd23 : (c_e < -10'sd3 ? 10'sd26 : 10'sd23 - c_e));
  assign n = rem < SPC ? rem : SPC;
  assign gi = 5'(n - 6'd1);
  assign lo = 32'((33'd1 << gi) - 33'd1);
  assign rup = g & (s | val[0]);
  assign mag = {1'b0, val} + {32'd0, rup};
  assign x = g | s;
  assign res_r = uns ? (sgn ? (mag != '0 ? {32'd0, 2'b10} : {32'd0, 1'b0, x})
                            : (mag > {1'b0, UINT32_MAX} ? {UINT32_MAX, 2'b10} : {mag[31:0], 1'b0, x}))
                     : (sgn ? (mag > {1'b0, INT32_MIN} ? {INT32_MIN, 2'b10} : {-mag[31:0], 1'b0, x})
                            : (mag > {1'b0, INT32_MAX} ? {INT32_MAX, 2'b10} : {mag[31:0], 1'b0, x}));
  always_comb
    nxt = state == IDLE ? (in_valid ? (sp ? DONE : cnt == '0 ? ROUND : SHIFT) : IDLE)
        : state == SHIFT ? (rem <= SPC ? ROUND : SHIFT)
        : state == ROUND ? DONE
        : (out_ready ? IDLE : DONE);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {out_data, invalid, inexact} <= '0;
      val <= '0;
      {g, s, sgn, uns, left_r} <= '0;
      rem <= '0;
    end else begin
      state <= nxt;
      if (in_valid && in_ready) begin
        {out_data, invalid, inexact} <= sp_r;
        val <= 32'(c_m);
        {g, s} <= 2'b00;
        sgn <= c_sign;
        uns <= u_in;
        left_r <= left;
        rem <= cnt;
      end else if (state == SHIFT) begin
        val <= left_r ? val << n : val >> n;
        g <= left_r ? g : val[gi];
        s <= left_r ? s : s | g | (|(val & lo));
        rem <= rem - n;
      end else if (state == ROUND) {out_data, invalid, inexact} <= res_r;
    end
endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// tb_fp32_to_int32_seq: directed and random checks of two converter instances (4 and 1 shift bits per cycle)
module tb_fp32_to_int32_seq;
  import fp32_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] iv = '0, ir, ov, ordy = '0, inv, inx;
  logic [31:0] in_data = '0, cur = '0;
  logic [31:0] od [2];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  fp32_to_int32_seq #(.SHIFT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
`ifdef FP_CVT_UNSIGNED_EN
    .in_unsigned(1'b0),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .invalid(inv[0]), .inexact(inx[0]));
  fp32_to_int32_seq #(.SHIFT_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
`ifdef FP_CVT_UNSIGNED_EN
    .in_unsigned(1'b0),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .invalid(inv[1]), .inexact(inx[1]));

  // Reference: exact integer/fraction split, then round-half-even and clamp to int32
  function automatic logic [33:0] ref_cvt(input logic [31:0] f);
    int ex = int'(f[30:23]);
    longint m = longint'(f[22:0]);
    longint ip, rm, mg;
    bit up = 1'b0;
    int e, sh;
    if (ex == 255) return (m != 0 || !f[31]) ? {INT32_MAX, 2'b10} : {INT32_MIN, 2'b10};
    if (ex == 0) return {32'd0, 1'b0, m != 0};
    m = m + (64'd1 << 23);
    e = ex - 127;
    if (e >= 40) return f[31] ? {INT32_MIN, 2'b10} : {INT32_MAX, 2'b10};
    if (e >= 23) begin
      ip = m << (e - 23);
      rm = 0;
    end else begin
      sh = 23 - e;
      if (sh >= 40) begin
        ip = 0;
        rm = m;
      end else begin
        ip = m >> sh;
        rm = m - (ip << sh);
        up = (2 * rm > (64'd1 << sh)) || (2 * rm == (64'd1 << sh) && ip[0]);
      end
    end
    mg = ip + longint'(up);
    if (!f[31] && mg > 64'd2147483647) return {INT32_MAX, 2'b10};
    if (f[31] && mg > 64'd2147483648) return {INT32_MIN, 2'b10};
    return {f[31] ? 32'(-mg) : 32'(mg), 1'b0, rm != 0};
  endfunction

  function automatic int exp_lat(input logic [31:0] f, input int spc);
    int ex = int'(f[30:23]);
    int e = ex - 127;
    int c;
    if (ex == 0 || ex == 255) return 1;
    if (e >= 31 && !(f[31] && e == 31 && f[22:0] == 0)) return 1;
    c = e >= 23 ? e - 23 : (23 - e > 26 ? 26 : 23 - e);
    return 2 + (c + spc - 1) / spc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s (op %h): observed %0h expected %0h", tag, cur, o, e);
    end
  endtask

  task automatic run(input int w, input logic [31:0] f, input logic [33:0] er, input int el, input int stall);
    int lat;
    cur = f;
    in_data = f;
    iv[w] = 1'b1;
    @(posedge clk);
    #1 iv[w] = 1'b0;
    lat = 1;
    while (!ov[w] && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    nvec++;
    chk("latency", 64'(lat), 64'(el));
    chk("data", 64'(od[w]), 64'(er[33:2]));
    chk("invalid", 64'(inv[w]), 64'(er[1]));
    chk("inexact", 64'(inx[w]), 64'(er[0]));
    for (int i = 0; i < stall; i++) begin
      in_data = $urandom;
      iv[w] = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_hold", 64'({od[w], inv[w], inx[w]}), 64'(er));
      chk("stall_ready", 64'(ir[w]), 64'd0);
      chk("stall_valid", 64'(ov[w]), 64'd1);
    end
    iv[w] = 1'b0;
    ordy[w] = 1'b1;
    @(posedge clk);
    #1 ordy[w] = 1'b0;
    chk("release", 64'({ov[w], ir[w]}), 64'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ir), 64'd3);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_out", 64'({od[0], inv[0], inx[0]}), 64'd0);
    rst = 1'b0;
    run(0, 32'h3FC0_0000, {32'h0000_0002, 2'b01}, 2 + 6, 0);
    run(0, 32'h4020_0000, {32'h0000_0002, 2'b01}, 2 + 6, 0);
    run(0, 32'h3F00_0000, {32'h0000_0000, 2'b01}, 2 + 6, 0);
    run(0, 32'hC060_0000, {32'hFFFF_FFFC, 2'b01}, 2 + 6, 5);
    run(0, 32'hC2F6_0000, {32'hFFFF_FF85, 2'b00}, 2 + 5, 0);
    run(0, 32'h4EFF_FFFF, {32'h7FFF_FF80, 2'b00}, 2 + 2, 0);
    run(0, 32'h4F00_0000, {32'h7FFF_FFFF, 2'b10}, 1, 0);
    run(0, 32'hCF00_0000, {32'h8000_0000, 2'b00}, 2 + 2, 0);
    run(0, 32'hCF00_0001, {32'h8000_0000, 2'b10}, 1, 0);
    run(0, 32'h7FC0_0000, {32'h7FFF_FFFF, 2'b10}, 1, 0);
    run(0, 32'hFF80_0000, {32'h8000_0000, 2'b10}, 1, 0);
    run(0, 32'h0000_0001, {32'h0000_0000, 2'b01}, 1, 0);
    run(0, 32'h8000_0000, {32'h0000_0000, 2'b00}, 1, 0);
    run(0, 32'h3F80_0000, {32'h0000_0001, 2'b00}, 8, 0);
    run(1, 32'h3F80_0000, {32'h0000_0001, 2'b00}, 25, 0);
    run(1, 32'hC060_0000, {32'hFFFF_FFFC, 2'b01}, 2 + 22, 0);
    cur = 32'h3F80_0000;
    in_data = cur;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_ready", 64'(ir[0]), 64'd1);
    chk("rst_mid_valid", 64'(ov[0]), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | ov[0];
    end
    chk("rst_no_result", 64'(seen), 64'd0);
    for (int i = 0; i < 160; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(100, 160));
      run(0, r, ref_cvt(r), exp_lat(r, 4), 0);
    end
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      r[30:23] = 8'($urandom_range(110, 160));
      run(1, r, ref_cvt(r), exp_lat(r, 1), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
